// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the per-lane receive frame parser.
// Holds the parser state encoding, default frame markers and length,
// and the transceiver status values that mark a usable word.
package rx_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        TS      = 2'd1,
        PAYLOAD = 2'd2,
        END     = 2'd3
    } rx_state_t;

    localparam int          DEFAULT_FRAME_LEN  = 128;
    localparam logic [15:0] DEFAULT_START_WORD = 16'hDEAD;
    localparam logic [15:0] DEFAULT_END_WORD   = 16'h7FFF;

    localparam logic [1:0]  LINK_SYNC_OK  = 2'b11;
    localparam logic [1:0]  LINK_DATAK_OK = 2'b00;

    // A word is usable only when both sync bits are locked and it carries no control flags.
    function automatic logic word_qualified(input logic [1:0] syncstatus, input logic [1:0] datak);
        return (syncstatus == LINK_SYNC_OK) && (datak == LINK_DATAK_OK);
    endfunction

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating event counter: adds one per cycle with inc set and sticks at
// all-ones instead of wrapping. Synchronous active-low reset.
module rx_sat_counter
    import rx_frame_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    // Count up on each requested increment until the counter is full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_parser.sv
// Per-lane receive frame parser. Qualifies the link, hunts for the start
// word, captures the frame time stamp, streams indexed payload samples and
// flags good end words, malformed/aborted frames and time-stamp gaps.
// Optional feature macro: RX_FRAME_TS_CHECK_EN enables the time-stamp
// continuity check; without it ts_gap is constant 0 and no history is kept.
module rx_frame_parser
    import rx_frame_pkg::*;
#(
    parameter int          FRAME_LEN  = DEFAULT_FRAME_LEN,
    parameter logic [15:0] START_WORD = DEFAULT_START_WORD,
    parameter logic [15:0] END_WORD   = DEFAULT_END_WORD
) (
    input  logic        rx_std_clkout,
    input  logic        rst_n,
    input  logic [1:0]  rx_syncstatus,
    input  logic [1:0]  rx_datak,
    input  logic [15:0] RX_data,
    output logic        link_up,
    output logic        sample_valid,
    output logic [15:0] sample_data,
    output logic [6:0]  sample_index,
    output logic [15:0] frame_ts,
    output logic        frame_ts_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic        ts_gap,
    output logic [15:0] err_count
);

    // Index of the final payload word; the index counter is 7 bits wide.
    localparam logic [6:0] LAST_IDX = 7'(FRAME_LEN - 4);

    rx_state_t   state;
    logic [6:0]  payload_idx;
    logic        qualified;
    logic        err_event;
    logic        done_event;
    logic        gap_event;

`ifdef RX_FRAME_TS_CHECK_EN
    logic [15:0] last_ts;
    logic        ts_armed;
`endif

    // Classify the incoming word: link quality, end-of-frame outcome and abort.
    always_comb begin
        qualified  = word_qualified(rx_syncstatus, rx_datak);
        err_event  = 1'b0;
        done_event = 1'b0;
        if (state != HUNT && !qualified) begin
            err_event = 1'b1;
        end else if (state == END) begin
            if (RX_data == END_WORD) begin
                done_event = 1'b1;
            end else begin
                err_event = 1'b1;
            end
        end
    end

`ifdef RX_FRAME_TS_CHECK_EN
    // A time stamp that does not follow the last good frame's stamp is a gap.
    always_comb begin
        gap_event = 1'b0;
        if (state == TS && qualified && ts_armed && (RX_data != last_ts + 16'd1)) begin
            gap_event = 1'b1;
        end
    end

    // Remember the stamp of the last cleanly ended frame; any error disarms the check.
    always_ff @(posedge rx_std_clkout) begin
        if (!rst_n) begin
            last_ts  <= '0;
            ts_armed <= 1'b0;
        end else if (err_event) begin
            ts_armed <= 1'b0;
        end else if (done_event) begin
            last_ts  <= frame_ts;
            ts_armed <= 1'b1;
        end
    end
`else
    // Without the continuity check there is never a gap.
    always_comb begin
        gap_event = 1'b0;
    end
`endif

    // Frame state machine with all outputs registered one cycle after the sampled word.
    always_ff @(posedge rx_std_clkout) begin
        if (!rst_n) begin
            state          <= HUNT;
            payload_idx    <= '0;
            link_up        <= 1'b0;
            sample_valid   <= 1'b0;
            sample_data    <= '0;
            sample_index   <= '0;
            frame_ts       <= '0;
            frame_ts_valid <= 1'b0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            ts_gap         <= 1'b0;
        end else begin
            link_up        <= qualified;
            sample_valid   <= 1'b0;
            frame_ts_valid <= 1'b0;
            frame_done     <= done_event;
            frame_err      <= err_event;
            ts_gap         <= gap_event;
            case (state)
                HUNT: begin
                    if (qualified && RX_data == START_WORD) begin
                        state <= TS;
                    end
                end
                TS: begin
                    if (!qualified) begin
                        state <= HUNT;
                    end else begin
                        frame_ts       <= RX_data;
                        frame_ts_valid <= 1'b1;
                        payload_idx    <= '0;
                        state          <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!qualified) begin
                        state <= HUNT;
                    end else begin
                        sample_valid <= 1'b1;
                        sample_data  <= RX_data;
                        sample_index <= payload_idx;
                        payload_idx  <= payload_idx + 7'd1;
                        if (payload_idx == LAST_IDX) begin
                            state <= END;
                        end
                    end
                end
                END: begin
                    state <= HUNT;
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

    // Count frame errors and time-stamp gaps together, once per cycle, saturating.
    rx_sat_counter #(
        .WIDTH(16)
    ) u_err_counter (
        .clk   (rx_std_clkout),
        .rst_n (rst_n),
        .inc   (err_event | gap_event),
        .count (err_count)
    );

endmodule
